tlb_arbiter: RTL
================

TLB_ARBITER -- requirements
Module: tlb_arbiter

Interface
REQ-001 SHALL have parameter PT_ENTRY_BYTES, default 4: page-table entry size for walk address generation.
REQ-002 SHALL have parameter WALK_TIMEOUT, default 255: max cycles waiting for pt_ack before abort.
REQ-003 SHALL have ports clk in 1 (single clock) and rst in 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports rq_valid in 2 (request per requester, 0=ifetch, 1=dmem) and rq_vaddr in 2x bit_count (virtual address per requester).
REQ-005 SHALL have ports rq_ready out 2 (request accepted this cycle), rs_valid out 2 (one-cycle result pulse), rs_paddr out bit_count (translated address) and rs_error out 1 (walk aborted, valid with rs_valid).
REQ-006 SHALL have ports tlb_enable out 1, tlb_compare out bit_count, tlb_unfault out 1, tlb_fault_input out bit_count, tlb_compare_output in bit_count and tlb_fault in 1 to the TLB.
REQ-007 SHALL have ports pt_base in bit_count (page-table base), pt_req out 1, pt_addr out bit_count, pt_ack in 1 and pt_data in bit_count (page-table read port).

Function
REQ-008 SHALL implement states IDLE, LOOKUP, CHECK, WALK, FILL, RETRY, RESP.
REQ-009 IDLE: when any rq_valid, SHALL grant one requester, pulse its rq_ready for one cycle, latch its vaddr and index, and move to LOOKUP; no grant in any other state.
REQ-010 LOOKUP: SHALL drive tlb_enable=1 and tlb_compare=latched vaddr for exactly one cycle, then go to CHECK.
REQ-011 CHECK: tlb_fault=0 SHALL latch tlb_compare_output and go to RESP; tlb_fault=1 SHALL go to WALK.
REQ-012 WALK: SHALL hold pt_req=1 with pt_addr = pt_base + VPN*PT_ENTRY_BYTES, VPN = vaddr[bit_count-1:$clog2(page_size)], truncated to bit_count; on pt_ack SHALL latch pt_data, drop pt_req and go to FILL.
REQ-013 WALK timeout: after WALK_TIMEOUT cycles without pt_ack SHALL drop pt_req, set the error flag and go to RESP; the TLB is left in fault state.
REQ-014 FILL: SHALL pulse tlb_unfault=1 with tlb_fault_input=latched pt_data for one cycle, then go to RETRY.
REQ-015 RETRY: SHALL re-enter LOOKUP; a second consecutive fault on the same request SHALL set the error flag and go to RESP.
REQ-016 RESP: SHALL pulse rs_valid[granted]=1 for one cycle with rs_paddr and rs_error, clear the error flag, and return to IDLE.
REQ-017 Hit latency SHALL be 4 cycles from grant cycle to rs_valid (grant, LOOKUP, CHECK, RESP).
REQ-018 Simultaneous rq_valid in IDLE SHALL be resolved per REQ-023; the loser stays pending with no data loss; requesters hold rq_valid/rq_vaddr until rq_ready.
REQ-019 tlb_enable, tlb_unfault, pt_req and rs_valid SHALL never be asserted together.

Reset
REQ-020 rst SHALL asynchronously force IDLE and clear all outputs, latches, timeout counter, error flag and round-robin pointer to 0.
REQ-021 rst mid-walk SHALL drop pt_req immediately; a pt_ack arriving after reset release SHALL be ignored in IDLE.

Configuration
REQ-022 Macro TLB_ARB_RR_EN SHALL select the arbitration policy.
REQ-023 Defined: round-robin, pointer advances past the last granted requester; undefined: fixed priority, requester 1 (dmem) wins ties.

Structure
REQ-024 State enum, requester-index typedef and PT_ENTRY_BYTES default SHALL live in cpu_params beside bit_count, page_size, ram_address_width.
REQ-025 SHALL contain one sub-module tlb_rr_picker (2-input grant logic, honours TLB_ARB_RR_EN); the FSM stays in tlb_arbiter.

Verification
REQ-026 Hit: TLB model returns fault=0, paddr 0x1000000A for vaddr 0xFFFFF00A on req0 -> rs_valid[0] 4 cycles after grant, rs_paddr=0x1000000A, rs_error=0.
REQ-027 Miss: fault=1, pt_base=0x00010000, vaddr 0x00003004, page_size 4096 -> pt_addr=0x0001000C, unfault pulse with pt_data, retry hit, rs_valid with rs_error=0.
REQ-028 Contention: both rq_valid held for 4 requests -> RR build grants 0,1,0,1; fixed build grants 1 until req1 drops.
REQ-029 Timeout: pt_ack never asserted, WALK_TIMEOUT=8 -> pt_req drops after 8 cycles, rs_valid with rs_error=1.
REQ-030 Double fault: TLB faults after fill -> rs_error=1, no third LOOKUP.
REQ-031 Reset in WALK: assert rst with pt_req=1 -> pt_req=0 at once, state IDLE, later pt_ack ignored, no rs_valid.

Source files
------------

// File: rtl/cpu_params.sv
// Shared CPU parameters and types used by the TLB arbiter and its grant logic.
package cpu_params;

    localparam int bit_count              = 32;
    localparam int page_size              = 4096;
    localparam int ram_address_width      = 16;
    localparam int page_shift             = $clog2(page_size);
    localparam int pt_entry_bytes_default = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        WALK,
        FILL,
        RETRY,
        RESP
    } arb_state_t;

    // Index of a requester: 0 = ifetch, 1 = dmem.
    typedef logic [0:0] req_idx_t;

    // Page-table entry address for a virtual address; wraps at bit_count bits.
    function automatic logic [bit_count-1:0] walk_addr(
        input logic [bit_count-1:0] base,
        input logic [bit_count-1:0] vaddr,
        input int                   entry_bytes
    );
        logic [bit_count-1:0] vpn;
        vpn = vaddr >> page_shift;
        return base + vpn * bit_count'(entry_bytes);
    endfunction

endpackage

// File: rtl/tlb_rr_picker.sv
// Two-requester grant logic. Round-robin when TLB_ARB_RR_EN is defined,
// otherwise fixed priority with requester 1 (dmem) winning ties.
module tlb_rr_picker
    import cpu_params::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic [1:0] req,
    input  logic     advance,
    output logic [1:0] grant,
    output req_idx_t grant_idx
);

`ifdef TLB_ARB_RR_EN
    req_idx_t ptr;

    // The pointer names the requester that wins the next tie.
    always_comb begin
        grant_idx = req[ptr] ? ptr : ~ptr;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && |req) begin
            ptr <= ~grant_idx;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst ^ advance;

    always_comb begin
        grant_idx = req_idx_t'(req[1]);
    end
`endif

    always_comb begin
        grant = '0;
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tlb_arbiter.sv
// Arbitrates ifetch/dmem translation requests onto one TLB, walking the page
// table on a miss. Arbitration policy selected by macro TLB_ARB_RR_EN.
module tlb_arbiter
    import cpu_params::*;
#(
    parameter int PT_ENTRY_BYTES = pt_entry_bytes_default,
    parameter int WALK_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                rq_valid,
    input  logic [1:0][bit_count-1:0] rq_vaddr,
    output logic [1:0]                rq_ready,
    output logic [1:0]                rs_valid,
    output logic [bit_count-1:0]      rs_paddr,
    output logic                      rs_error,
    output logic                      tlb_enable,
    output logic [bit_count-1:0]      tlb_compare,
    output logic                      tlb_unfault,
    output logic [bit_count-1:0]      tlb_fault_input,
    input  logic [bit_count-1:0]      tlb_compare_output,
    input  logic                      tlb_fault,
    input  logic [bit_count-1:0]      pt_base,
    output logic                      pt_req,
    output logic [bit_count-1:0]      pt_addr,
    input  logic                      pt_ack,
    input  logic [bit_count-1:0]      pt_data
);

    localparam int cnt_w = $clog2(WALK_TIMEOUT + 1);
    localparam logic [cnt_w-1:0] timeout_last = cnt_w'(WALK_TIMEOUT - 1);

    arb_state_t           state, next_state;
    logic [bit_count-1:0] vaddr_q, paddr_q, pte_q;
    req_idx_t             idx_q, grant_idx;
    logic [1:0]           grant;
    logic                 err_q, retry_q;
    logic [cnt_w-1:0]     walk_cnt;

    tlb_rr_picker u_picker (
        .clk       (clk),
        .rst       (rst),
        .req       (rq_valid),
        .advance   (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vaddr_q  <= '0;
            paddr_q  <= '0;
            pte_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            retry_q  <= 1'b0;
            walk_cnt <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (|rq_valid) begin
                        vaddr_q <= rq_vaddr[grant_idx];
                        idx_q   <= grant_idx;
                        paddr_q <= '0;
                        err_q   <= 1'b0;
                        retry_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!tlb_fault) begin
                        paddr_q <= tlb_compare_output;
                    end else if (retry_q) begin
                        err_q <= 1'b1;
                    end
                end
                WALK: begin
                    if (pt_ack) begin
                        pte_q    <= pt_data;
                        walk_cnt <= '0;
                    end else if (walk_cnt == timeout_last) begin
                        err_q    <= 1'b1;
                        walk_cnt <= '0;
                    end else begin
                        walk_cnt <= walk_cnt + cnt_w'(1);
                    end
                end
                RETRY:   retry_q <= 1'b1;
                RESP:    err_q   <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: every output and next_state gets a default first, so no latches.
    always_comb begin
        next_state      = state;
        rq_ready        = '0;
        rs_valid        = '0;
        rs_error        = 1'b0;
        tlb_enable      = 1'b0;
        tlb_compare     = '0;
        tlb_unfault     = 1'b0;
        tlb_fault_input = '0;
        pt_req          = 1'b0;
        pt_addr         = '0;
        case (state)
            IDLE: begin
                // Gated by rst so no handshake can appear while held in reset.
                if (|rq_valid && !rst) begin
                    rq_ready   = grant;
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                tlb_enable  = 1'b1;
                tlb_compare = vaddr_q;
                next_state  = CHECK;
            end
            CHECK: begin
                next_state = (tlb_fault && !retry_q) ? WALK : RESP;
            end
            WALK: begin
                pt_req  = 1'b1;
                pt_addr = walk_addr(pt_base, vaddr_q, PT_ENTRY_BYTES);
                if (pt_ack) begin
                    next_state = FILL;
                end else if (walk_cnt == timeout_last) begin
                    next_state = RESP;
                end
            end
            FILL: begin
                tlb_unfault     = 1'b1;
                tlb_fault_input = pte_q;
                next_state      = RETRY;
            end
            RETRY: next_state = LOOKUP;
            RESP: begin
                rs_valid[idx_q] = 1'b1;
                rs_error        = err_q;
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign rs_paddr = paddr_q;

endmodule
